// File: rtl/add_sub_serial_if.sv
// Operand/result bundle for the bit-serial adder/subtractor.
// The requester drives start/mode/operands; the serial unit returns status and results.
interface add_sub_serial_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [1:0]       mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, mode, a, b,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, mode, a, b,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/add_sub_serial.sv
// Bit-serial add/subtract unit, LSB first, one full adder and one carry flop.
// Modes 1x take operand A from an accumulator that holds the last result.
//
//   state | meaning
//   IDLE  | waiting for start
//   RUN   | shifting one bit per clock, WIDTH cycles
//   DONE  | result valid, done pulse; start here chains the next operation
module add_sub_serial #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  add_sub_serial_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] sum_q;
  logic             carry;
  logic             cout_q;
  logic             ovf_q;
  logic [CW-1:0]    cnt;
  logic             s_bit;
  logic             c_next;

  assign s_bit  = a_sr[0] ^ b_sr[0] ^ carry;
  assign c_next = (a_sr[0] & b_sr[0]) | (carry & (a_sr[0] ^ b_sr[0]));

  // Sum bits are shifted into the vacated MSB end of the A register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      acc    <= '0;
      sum_q  <= '0;
      carry  <= 1'b0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state)
        RUN: begin
          a_sr  <= {s_bit, a_sr[WIDTH-1:1]};
          b_sr  <= {1'b0, b_sr[WIDTH-1:1]};
          carry <= c_next;
          if (cnt == '0) begin
            state  <= DONE;
            sum_q  <= {s_bit, a_sr[WIDTH-1:1]};
            acc    <= {s_bit, a_sr[WIDTH-1:1]};
            cout_q <= c_next;
            ovf_q  <= carry ^ c_next;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: begin
          if (bus.start) begin
            state <= RUN;
            a_sr  <= bus.mode[1] ? acc : bus.a;
            b_sr  <= bus.mode[0] ? ~bus.b : bus.b;
            carry <= bus.mode[0];
            cnt   <= CW'(WIDTH - 1);
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

  assign bus.busy = (state == RUN);
  assign bus.done = (state == DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;
endmodule

// File: doc/add_sub_serial.md
ADD_SUB_SERIAL -- requirements
Module: add_sub_serial

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand/result width in bits; legal range 2..32.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port start  input  1  request to begin an operation.
REQ-005 SHALL have port mode  input  2  operation select: 00 A+B, 01 A-B, 10 ACC+B, 11 ACC-B.
REQ-006 SHALL have port a  input  WIDTH  operand A, used in modes 00/01 only.
REQ-007 SHALL have port b  input  WIDTH  operand B.
REQ-008 SHALL have port busy  output  1  high while an operation is in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse marking a new result.
REQ-010 SHALL have port sum  output  WIDTH  registered result.
REQ-011 SHALL have port cout  output  1  carry out of the MSB (for subtract: 1 = no borrow).
REQ-012 SHALL have port ovf  output  1  two's-complement signed overflow of the result.

Function
REQ-013 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-014 SHALL accept start only in IDLE or DONE; the accepting edge captures a, b and mode and enters RUN; start is ignored in RUN.
REQ-015 SHALL, in modes 10/11, use the internal accumulator ACC as operand A and ignore a.
REQ-016 SHALL compute bit-serially, LSB first, one bit per clock, through a single full adder and a 1-bit carry flop.
REQ-017 SHALL initialise the carry flop to mode[0] and invert B when mode[0]=1 (A + ~B + 1 for subtract).
REQ-018 SHALL stay in RUN for exactly WIDTH cycles, then enter DONE.
REQ-019 SHALL hold busy=1 in every RUN cycle and busy=0 in IDLE and DONE.
REQ-020 SHALL assert done for exactly one cycle, in DONE, WIDTH edges after the edge that accepted start.
REQ-021 SHALL update sum, cout and ovf only on entry to DONE; the outputs hold until the next completion.
REQ-022 SHALL set ovf = (carry into MSB) XOR (carry out of MSB).
REQ-023 SHALL load ACC with the final sum on entry to DONE, for every mode.
REQ-024 SHALL return from DONE to IDLE when start=0, or re-enter RUN when start=1 (back-to-back operations at a WIDTH+1 cycle period).
REQ-025 SHALL wrap results modulo 2^WIDTH; no saturation.
REQ-026 SHALL leave an in-flight operation unaffected by changes on a, b or mode after capture.

Reset
REQ-027 SHALL, on a clock edge with rst=1, force IDLE, busy=0, done=0, sum=0, cout=0, ovf=0, ACC=0 and carry=0.
REQ-028 SHALL let rst take priority over start at the same edge.
REQ-029 SHALL abort an operation reset mid-RUN; no done pulse follows and the previous results are lost (cleared to zero).

Verification (WIDTH=4)
REQ-030 SHALL cover: reset, then mode=00, a=0111, b=0001 -> done exactly 4 edges after the start edge, sum=1000, cout=0, ovf=1, busy high 4 cycles.
REQ-031 SHALL cover: mode=01, a=1000, b=0001 -> sum=0111, cout=1, ovf=1; then mode=01, a=0001, b=0010 -> sum=1111, cout=0, ovf=0.
REQ-032 SHALL cover: after reset, mode=10 b=0101 -> sum=0101; mode=10 b=1111 -> sum=0100, cout=1, ovf=0; mode=11 b=0110 -> sum=1110, cout=0, ovf=0.
REQ-033 SHALL cover: start held high continuously with mode=00, a=b=1111 -> done every 5 cycles, sum=1110, cout=1, ovf=0; start pulses during RUN ignored.
REQ-034 SHALL cover: rst asserted in the 2nd RUN cycle -> busy=0 next cycle, no done pulse, all outputs 0, ACC=0 (next mode=10 b=0011 gives sum=0011).
REQ-035 SHALL cover: a and b toggled every cycle during RUN -> result equals the operands captured at start.
